// File: rtl/uart_rx_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer_if
// Brief    : Received-byte valid/ready channel between the deframer and the
//            APB register block.
// Revision : 1.0
// ============================================================================
interface uart_rx_deframer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Brief    : 16x-oversampling UART receive deframer with a single-entry output
//            buffer and sticky parity/frame/overrun flags.
// Revision : 1.0
// ============================================================================
module uart_rx_deframer #(
    parameter int DIV_B0    = 326,
    parameter int DIV_B1    = 163,
    parameter int DIV_B2    = 81,
    parameter int DIV_B3    = 27,
    parameter int DATA_BITS = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       uart_rx,
    input  wire logic [1:0] uart_baud_rate,
    input  wire logic [1:0] uart_parity_type,
    input  wire logic       err_clr,
    output logic            uart_rx_active,
    output logic            uart_rx_done,
    output logic [2:0]      uart_error,
    uart_rx_deframer_if.master rx_if
);

    localparam int c_DIV_W = 16;
    localparam int c_BCW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2, r_rx_prev;
    logic                 w_rx_s;
    logic [1:0]           r_baud, r_ptype;
    logic [c_DIV_W-1:0]   r_div, w_div_last;
    logic                 w_tick;
    logic [3:0]           r_tick_cnt;
    logic [c_BCW-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_par_err, r_valid, r_done;
    logic [2:0]           r_err, w_err_set;
    logic                 w_par_en, w_start_det, w_data_smp, w_par_smp, w_stop_smp;

    assign w_rx_s   = r_sync2;
    assign w_par_en = (r_ptype == 2'b01) || (r_ptype == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx_s;
        end
    end

    always_comb begin
        case (r_baud)
            2'b00:   w_div_last = c_DIV_W'(DIV_B0 - 1);
            2'b01:   w_div_last = c_DIV_W'(DIV_B1 - 1);
            2'b10:   w_div_last = c_DIV_W'(DIV_B2 - 1);
            default: w_div_last = c_DIV_W'(DIV_B3 - 1);
        endcase
    end

    assign w_tick = (r_div == w_div_last);

    // Divider and tick count restart on the start edge so sampling lands mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_baud     <= 2'b00;
            r_ptype    <= 2'b00;
        end else if (w_start_det) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_baud     <= uart_baud_rate;
            r_ptype    <= uart_parity_type;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick)
                r_tick_cnt <= (r_state == S_START && r_tick_cnt == 4'd7) ? 4'd0 : r_tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_det = 1'b0;
        w_data_smp  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !w_rx_s) begin
                    w_start_det = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick && r_tick_cnt == 4'd7)
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && r_tick_cnt == 4'd15) begin
                    w_data_smp = 1'b1;
                    if (r_bit_cnt == c_BCW'(DATA_BITS - 1))
                        w_state_nxt = w_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_tick && r_tick_cnt == 4'd15) begin
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && r_tick_cnt == 4'd15) begin
                    w_stop_smp  = 1'b1;
                    w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else if (w_start_det) begin
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_data_smp) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
            // Odd parity expects the XOR of data and parity bit to be 1.
            if (w_par_smp)
                r_par_err <= (^r_shift) ^ w_rx_s ^ (r_ptype == 2'b01);
        end
    end

    assign w_err_set = {w_stop_smp & r_valid & ~rx_if.rx_ready,
                        w_stop_smp & ~w_rx_s,
                        w_stop_smp & r_par_err};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_done <= w_stop_smp;
            r_err  <= (r_err & ~{3{err_clr}}) | w_err_set;
            if (w_stop_smp && (!r_valid || rx_if.rx_ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data  = r_data;
    assign rx_if.rx_valid = r_valid;
    assign uart_rx_done   = r_done;
    assign uart_error     = r_err;
    assign uart_rx_active = (r_state == S_START) || (r_state == S_DATA) ||
                            (r_state == S_PARITY) || (r_state == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deframer
// Brief    : Self-checking bench driving serial frames into uart_rx_deframer.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_deframer;

    localparam int BIT = 16 * 27;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [1:0] baud, ptype;
    logic       err_clr;
    logic       active, done;
    logic [2:0] err;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt  = 0;
    int act_cnt   = 0;
    int valid_cnt = 0;
    logic [7:0] got_q[$];

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rx         (uart_rx),
        .uart_baud_rate  (baud),
        .uart_parity_type(ptype),
        .err_clr         (err_clr),
        .uart_rx_active  (active),
        .uart_rx_done    (done),
        .uart_error      (err),
        .rx_if           (rx_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (active) act_cnt++;
        if (rx_if.rx_valid) valid_cnt++;
        if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
    end

    task automatic hold(input logic b, input int clks);
        uart_rx = b;
        repeat (clks) @(negedge clk);
    endtask

    // Line leaves the stop-bit level in place; the caller decides what follows.
    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic stopb, input logic scramble);
        logic [1:0] sv_b, sv_p;
        sv_b = baud;
        sv_p = ptype;
        hold(1'b0, BIT);
        if (scramble) begin
            baud  = 2'($urandom);
            ptype = 2'($urandom);
        end
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        if (has_par) hold(pbit, BIT);
        hold(stopb, BIT);
        baud  = sv_b;
        ptype = sv_p;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({rx_if.rx_data, rx_if.rx_valid, active, done, err} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h valid=%b active=%b done=%b err=%b, want all 0",
                     rx_if.rx_data, rx_if.rx_valid, active, done, err);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int b_done, b_act, b_val, b_got;
        b_done = done_cnt; b_act = act_cnt; b_val = valid_cnt; b_got = got_q.size();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, BIT);
        n_chk++;
        if (got_q.size() != b_got + 1 || got_q[b_got] !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got %0d bytes (first %h), want 1 byte a5",
                     got_q.size() - b_got, (got_q.size() > b_got) ? got_q[b_got] : 8'hxx);
        end
        n_chk++;
        if (done_cnt - b_done != 1) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses, want 1", done_cnt - b_done);
        end
        n_chk++;
        if (valid_cnt - b_val != 1) begin
            n_fail++; $display("FAIL basic_valid_len: got %0d clks, want 1", valid_cnt - b_val);
        end
        n_chk++;
        if (err !== 3'b000) begin
            n_fail++; $display("FAIL basic_err: got %b, want 000", err);
        end
        n_chk++;
        if (act_cnt - b_act < 9 * BIT || act_cnt - b_act > 10 * BIT) begin
            n_fail++; $display("FAIL basic_active_len: got %0d clks, want %0d..%0d",
                               act_cnt - b_act, 9 * BIT, 10 * BIT);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       pb;
        int         b_got;
        d = 8'h3C;
        ptype = 2'b10;
        b_got = got_q.size();
        for (int k = 0; k < 2; k++) begin
            pb = 1'(k);
            send_frame(d, 1'b1, pb, 1'b1, 1'b0);
            hold(1'b1, BIT);
            n_chk++;
            if (err !== {2'b00, pb != (^d)}) begin
                n_fail++; $display("FAIL parity_err_%0d: got %b, want %b", k, err, {2'b00, pb != (^d)});
            end
            n_chk++;
            if (got_q.size() != b_got + k + 1 || got_q[b_got + k] !== d) begin
                n_fail++; $display("FAIL parity_data_%0d: got %0d bytes, want %0d ending with %h",
                                   k, got_q.size() - b_got, k + 1, d);
            end
        end
        pulse_clr();
        n_chk++;
        if (err !== 3'b000) begin
            n_fail++; $display("FAIL parity_clr: got %b, want 000", err);
        end
        ptype = 2'b00;
    endtask

    task automatic test_break();
        int b_done, b_got;
        b_done = done_cnt; b_got = got_q.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 3 * BIT);
        n_chk++;
        if (err !== 3'b010) begin
            n_fail++; $display("FAIL break_err: got %b, want 010", err);
        end
        n_chk++;
        if (done_cnt - b_done != 1) begin
            n_fail++; $display("FAIL break_done_low: got %0d pulses, want 1", done_cnt - b_done);
        end
        hold(1'b1, 2 * BIT);
        n_chk++;
        if (done_cnt - b_done != 1 || got_q.size() != b_got + 1 || got_q[b_got] !== 8'h55) begin
            n_fail++; $display("FAIL break_after: got %0d pulses %0d bytes, want 1 pulse 1 byte 55",
                               done_cnt - b_done, got_q.size() - b_got);
        end
        pulse_clr();
    endtask

    task automatic test_glitch();
        int b_done, b_val;
        b_done = done_cnt; b_val = valid_cnt;
        hold(1'b0, 4);
        hold(1'b1, 100);
        n_chk++;
        if (active !== 1'b1) begin
            n_fail++; $display("FAIL glitch_active_early: got %b, want 1", active);
        end
        hold(1'b1, 200);
        n_chk++;
        if (active !== 1'b0) begin
            n_fail++; $display("FAIL glitch_active_late: got %b, want 0", active);
        end
        hold(1'b1, BIT);
        n_chk++;
        if (done_cnt != b_done || valid_cnt != b_val || err !== 3'b000) begin
            n_fail++; $display("FAIL glitch_output: got done=%0d valid=%0d err=%b, want 0 0 000",
                               done_cnt - b_done, valid_cnt - b_val, err);
        end
    endtask

    task automatic test_overrun();
        int b_done, b_got;
        b_done = done_cnt; b_got = got_q.size();
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, BIT);
        n_chk++;
        if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h11 || err !== 3'b000) begin
            n_fail++; $display("FAIL overrun_first: got valid=%b data=%h err=%b, want 1 11 000",
                               rx_if.rx_valid, rx_if.rx_data, err);
        end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, BIT);
        n_chk++;
        if (rx_if.rx_data !== 8'h11 || err !== 3'b100 || done_cnt - b_done != 2) begin
            n_fail++; $display("FAIL overrun_second: got data=%h err=%b done=%0d, want 11 100 2",
                               rx_if.rx_data, err, done_cnt - b_done);
        end
        rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (rx_if.rx_valid !== 1'b0 || got_q.size() != b_got + 1 || got_q[b_got] !== 8'h11) begin
            n_fail++; $display("FAIL overrun_drain: got valid=%b bytes=%0d, want 0 and one byte 11",
                               rx_if.rx_valid, got_q.size() - b_got);
        end
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        int b_done, b_got;
        b_done = done_cnt; b_got = got_q.size();
        hold(1'b0, BIT);
        hold(1'b1, 4 * BIT + BIT / 2);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (active !== 1'b0 || rx_if.rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_state: got active=%b valid=%b, want 0 0",
                               active, rx_if.rx_valid);
        end
        reset = 1'b0;
        hold(1'b1, 4 * BIT);
        n_chk++;
        if (done_cnt != b_done || got_q.size() != b_got) begin
            n_fail++; $display("FAIL reset_mid_output: got %0d pulses %0d bytes, want 0 0",
                               done_cnt - b_done, got_q.size() - b_got);
        end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1'b1, BIT);
        n_chk++;
        if (got_q.size() != b_got + 1 || got_q[b_got] !== 8'h81 || err !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_next: got %0d bytes err=%b, want byte 81 err 000",
                               got_q.size() - b_got, err);
        end
    endtask

    // Reference: parity from the byte's population count, flags from frame content.
    task automatic test_random();
        logic [7:0] d;
        logic       pen, pinj, stopb, pb, good;
        logic [2:0] exp_err;
        int         b_done, b_got;
        for (int n = 0; n < 5; n++) begin
            d     = 8'($urandom);
            ptype = 2'($urandom_range(0, 3));
            pinj  = 1'($urandom_range(0, 1));
            stopb = ($urandom_range(0, 3) != 0);
            pen   = (ptype == 2'b01) || (ptype == 2'b10);
            good  = ($countones(d) % 2 == 1) ? (ptype == 2'b10) : (ptype == 2'b01);
            pb    = pinj ? ~good : good;
            exp_err = {1'b0, ~stopb, pen & pinj};
            b_done = done_cnt; b_got = got_q.size();
            send_frame(d, pen, pb, stopb, 1'b1);
            hold(1'b1, BIT);
            n_chk++;
            if (got_q.size() != b_got + 1 || got_q[b_got] !== d || err !== exp_err ||
                done_cnt - b_done != 1) begin
                n_fail++;
                $display("FAIL random_%0d: got bytes=%0d err=%b done=%0d, want byte %h err %b done 1",
                         n, got_q.size() - b_got, err, done_cnt - b_done, d, exp_err);
            end
            pulse_clr();
        end
        ptype = 2'b00;
    endtask

    initial begin
        uart_rx = 1'b1;
        baud    = 2'b11;
        ptype   = 2'b00;
        err_clr = 1'b0;
        rx_if.rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
